// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x (OVERSAMPLE) baud tick.
// The serial line is synchronised, the start bit is re-checked at mid-bit,
// DATA_BITS are shifted in LSB first, and the stop bit is sampled before the
// byte is handed to a one-entry holding register with a valid/ack handshake.
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 I_sys_clk,
    input  logic                 I_rst,
    input  logic                 I_baud_tick,
    input  logic                 I_rx,
    input  logic                 I_data_ack,
    output logic [DATA_BITS-1:0] O_rx_data,
    output logic                 O_data_valid,
    output logic                 O_frame_err,
    output logic                 O_overrun,
    output logic                 O_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] MID_TICK_C  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK_C = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT_C  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t                 state_q,    state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   deliver_s;

    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   data_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   busy_q;

    // Synchroniser chain on the asynchronous line; resets to the idle (high) level.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Next-state logic; everything advances only on baud ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        deliver_s  = 1'b0;
        if (I_baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        tick_cnt_d = '0;
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == MID_TICK_C) begin
                        if (!rx_s) begin
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = ST_DATA;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            tick_cnt_d = tick_cnt_q + TW'(1);
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == LAST_TICK_C) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT_C) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == LAST_TICK_C) begin
                        deliver_s  = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receive FSM state, counters, shift register and busy flag.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    // Holding register: a delivery always wins over a coincident ack.
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            rx_data_q    <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (deliver_s) begin
            rx_data_q    <= shift_q;
            frame_err_q  <= ~rx_s;
            data_valid_q <= 1'b1;
            overrun_q    <= data_valid_q & ~I_data_ack;
        end else begin
            overrun_q <= 1'b0;
            if (I_data_ack) begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign O_rx_data    = rx_data_q;
    assign O_data_valid = data_valid_q;
    assign O_frame_err  = frame_err_q;
    assign O_overrun    = overrun_q;
    assign O_busy       = busy_q;

endmodule
